puzzle_entry: RTL and testbench

- User-input front end for the 8-puzzle solver; it is the input side of the solver, opposite the display side that shows the solution moves.
- Debounces three push buttons and lets the user edit the 3x3 start board cell by cell.
- Checks the board for duplicate tiles and for solvability (inversion parity).
- Presents a packed board vector with a one-cycle start pulse to the solver.

---
 rtl/puzzle_entry.sv | 195 +++++++++++++++++++
 tb/tb_puzzle_entry.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/puzzle_entry.sv
// puzzle_entry: button-driven editor for the 8-puzzle start board.
// Conditions three raw buttons, lets the user step a cursor over the 3x3
// board and bump tile values, then checks the board for duplicate tiles and
// inversion parity. A valid board is presented with a one-cycle start pulse.
module puzzle_entry #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_W            = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_inc,
  input  logic        btn_next,
  input  logic        btn_back,
  output logic [35:0] board,
  output logic        board_valid,
  output logic        start,
  output logic [3:0]  cur_pos,
  output logic [3:0]  cur_val,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    S_EDIT,
    S_CHECK_DUP,
    S_CHECK_PAR,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_DUP  = 2'b01;
  localparam logic [1:0] ERR_PAR  = 2'b10;

  // ---------------------------------------------------------------------
  // Button conditioning; bit 0 = inc, bit 1 = next, bit 2 = back
  // ---------------------------------------------------------------------
  logic [2:0]      btn_raw;
  logic [2:0]      sync1, sync2;
  logic [2:0]      db, db_d;
  logic [2:0]      press;
  logic [DB_W-1:0] db_cnt [3];

  assign btn_raw = {btn_back, btn_next, btn_inc};

  // Synchronize, debounce and edge-detect each button independently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_d  <= '0;
      press <= '0;
      for (int b = 0; b < 3; b++) db_cnt[b] <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples the pre-edge value; blocking here would collapse the
      // two synchronizer stages into one.
      sync1 <= btn_raw;
      sync2 <= sync1;
      db_d  <= db;
      press <= db & ~db_d;
      for (int b = 0; b < 3; b++) begin
        if (sync2[b] == db[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          db[b]     <= sync2[b];
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + DB_W'(1);
        end
      end
    end
  end

  // Simultaneous presses cancel each other out.
  logic one_press, inc_go, next_go, back_go;
  assign one_press = $onehot(press);
  assign inc_go    = one_press & press[0];
  assign next_go   = one_press & press[1];
  assign back_go   = one_press & press[2];

  // ---------------------------------------------------------------------
  // Board storage and check sequencing
  // ---------------------------------------------------------------------
  state_t     state, state_nx;
  logic [3:0] cells [9];
  logic [3:0] idx;        // CHECK_DUP cell index
  logic [8:0] seen;       // tile values already seen during CHECK_DUP
  logic [3:0] pi, pj;     // CHECK_PAR pair (pi < pj)
  logic       parity;
  logic       dup_hit, par_hit, last_pair;
  logic [3:0] cell_a, cell_b;

  assign dup_hit   = seen[cells[idx]];
  assign cell_a    = cells[pi];
  assign cell_b    = cells[pj];
  assign par_hit   = (cell_a != 4'd0) && (cell_b != 4'd0) && (cell_a > cell_b);
  assign last_pair = (pi == 4'd7) && (pj == 4'd8);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_EDIT;
    else        state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: the default assignment first means every path through the case
    // assigns state_nx, so no latch is inferred.
    state_nx = state;
    case (state)
      S_EDIT:      if (next_go && cur_pos == 4'd8) state_nx = S_CHECK_DUP;
      S_CHECK_DUP: if (dup_hit)                    state_nx = S_ERROR;
                   else if (idx == 4'd8)           state_nx = S_CHECK_PAR;
      S_CHECK_PAR: if (last_pair)                  state_nx = (parity ^ par_hit) ? S_ERROR : S_DONE;
      S_DONE:      if (back_go)                    state_nx = S_EDIT;
      S_ERROR:     if (one_press)                  state_nx = S_EDIT;
      default:                                     state_nx = S_EDIT;
    endcase
  end

  // Cell edits, cursor, check bookkeeping, error code and start pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the cell array is only nine nibbles and must come up as the
      // goal board, so it is reset like any other register rather than
      // treated as an unreset memory.
      for (int k = 0; k < 9; k++) cells[k] <= (k == 8) ? 4'd0 : 4'(k + 1);
      cur_pos  <= '0;
      idx      <= '0;
      seen     <= '0;
      pi       <= 4'd0;
      pj       <= 4'd1;
      parity   <= 1'b0;
      err_code <= ERR_NONE;
      start    <= 1'b0;
    end else begin
      start <= (state_nx == S_DONE) && (state != S_DONE);
      case (state)
        S_EDIT: begin
          if (inc_go)
            cells[cur_pos] <= (cells[cur_pos] == 4'd8) ? 4'd0 : cells[cur_pos] + 4'd1;
          if (next_go && cur_pos != 4'd8) cur_pos <= cur_pos + 4'd1;
          if (back_go && cur_pos != 4'd0) cur_pos <= cur_pos - 4'd1;
          if (next_go && cur_pos == 4'd8) begin
            idx  <= '0;
            seen <= '0;
          end
        end
        S_CHECK_DUP: begin
          seen[cells[idx]] <= 1'b1;
          idx              <= idx + 4'd1;
          if (state_nx == S_ERROR) err_code <= ERR_DUP;
          if (state_nx == S_CHECK_PAR) begin
            pi     <= 4'd0;
            pj     <= 4'd1;
            parity <= 1'b0;
          end
        end
        S_CHECK_PAR: begin
          parity <= parity ^ par_hit;
          if (pj == 4'd8) begin
            pi <= pi + 4'd1;
            pj <= pi + 4'd2;
          end else begin
            pj <= pj + 4'd1;
          end
          if (state_nx == S_ERROR) err_code <= ERR_PAR;
        end
        S_DONE: begin
          if (back_go) cur_pos <= '0;
        end
        S_ERROR: begin
          if (one_press) begin
            cur_pos  <= '0;
            err_code <= ERR_NONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Output packing, straight from the cell registers.
  always_comb begin
    board = '0;
    for (int k = 0; k < 9; k++) board[4*k +: 4] = cells[k];
  end

  assign cur_val     = cells[cur_pos];
  assign board_valid = (state == S_DONE);

endmodule

// File: tb/tb_puzzle_entry.sv
// Self-checking bench for puzzle_entry with DEBOUNCE_CYCLES=4.
// A bench-side board model predicts each submission's outcome (kind and
// cycle of the first outcome event); predictions are queued at submit time
// and popped when the DUT produces its outcome.
module tb_puzzle_entry;

  localparam int DC       = 4;
  localparam int PRESS_AT = DC + 3;          // raw edge -> internal press
  localparam int DONE_AT  = PRESS_AT + 46;   // raw edge -> start / parity error

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_inc = 1'b0, btn_next = 1'b0, btn_back = 1'b0;
  logic [35:0] board;
  logic        board_valid, start;
  logic [3:0]  cur_pos, cur_val;
  logic [1:0]  err_code;

  puzzle_entry #(.DEBOUNCE_CYCLES(DC), .DB_W(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_inc(btn_inc), .btn_next(btn_next), .btn_back(btn_back),
    .board(board), .board_valid(board_valid), .start(start),
    .cur_pos(cur_pos), .cur_val(cur_val), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Board model
  int cells_m [9];
  int cur_m;

  typedef struct {
    int          kind;   // 0 done, 1 duplicate, 2 unsolvable
    int          cyc;    // cycles from raw next edge to first outcome
    logic [35:0] brd;
  } exp_t;

  exp_t sb [$];

  function automatic logic [35:0] pack_m();
    logic [35:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[4*k +: 4] = 4'(cells_m[k]);
    return r;
  endfunction

  function automatic void reset_model();
    for (int k = 0; k < 9; k++) cells_m[k] = (k == 8) ? 0 : k + 1;
    cur_m = 0;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    bit   seen [9];
    int   inv;
    e.brd = pack_m();
    for (int k = 0; k < 9; k++) seen[k] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (seen[cells_m[i]]) begin
        e.kind = 1;
        e.cyc  = PRESS_AT + i + 2;
        return e;
      end
      seen[cells_m[i]] = 1'b1;
    end
    inv = 0;
    for (int i = 0; i < 9; i++)
      for (int j = i + 1; j < 9; j++)
        if (cells_m[i] != 0 && cells_m[j] != 0 && cells_m[i] > cells_m[j]) inv++;
    e.kind = (inv % 2 == 1) ? 2 : 0;
    e.cyc  = DONE_AT;
    return e;
  endfunction

  // Drive a clean press (bits: back,next,inc) and let it settle.
  task automatic press(input logic [2:0] m);
    {btn_back, btn_next, btn_inc} = m;
    repeat (6) @(negedge clk);
    {btn_back, btn_next, btn_inc} = 3'b000;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_inc();
    press(3'b001);
    cells_m[cur_m] = (cells_m[cur_m] == 8) ? 0 : cells_m[cur_m] + 1;
    check("inc_cur_val", 36'(cur_val), 36'(cells_m[cur_m]));
  endtask

  task automatic do_next();
    press(3'b010);
    if (cur_m < 8) cur_m++;
    check("next_cur_pos", 36'(cur_pos), 36'(cur_m));
  endtask

  task automatic do_back();
    press(3'b100);
    if (cur_m > 0) cur_m--;
    check("back_cur_pos", 36'(cur_pos), 36'(cur_m));
  endtask

  task automatic goto_pos(input int p);
    while (cur_m < p) do_next();
    while (cur_m > p) do_back();
  endtask

  // Press next at cell 8 and watch for the outcome within a fixed budget.
  task automatic submit();
    exp_t e;
    int   first_c, kind, starts;
    sb.push_back(predict());
    first_c = 0;
    kind    = -1;
    starts  = 0;
    btn_next = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (c == 6) btn_next = 1'b0;
      if (start) starts++;
      if (first_c == 0 && (start || err_code != 2'b00)) begin
        first_c = c;
        kind    = start ? 0 : (err_code == 2'b01 ? 1 : 2);
      end
    end
    e = sb.pop_front();
    check("outcome_kind", 36'(kind), 36'(e.kind));
    check("outcome_cycle", 36'(first_c), 36'(e.cyc));
    check("start_pulses", 36'(starts), (e.kind == 0) ? 36'd1 : 36'd0);
    check("frozen_board", board, e.brd);
    if (e.kind == 0) check("board_valid_done", 36'(board_valid), 36'd1);
    else             check("err_code_held", 36'(err_code), (e.kind == 1) ? 36'd1 : 36'd2);
  endtask

  // Leave DONE/ERROR with the given press.
  task automatic leave(input logic [2:0] m);
    press(m);
    cur_m = 0;
    check("leave_cur_pos", 36'(cur_pos), 36'd0);
    check("leave_err_code", 36'(err_code), 36'd0);
    check("leave_valid", 36'(board_valid), 36'd0);
    check("leave_board", board, pack_m());
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_board"}, board, 36'h087654321);
    check({tag, "_cur_pos"}, 36'(cur_pos), 36'd0);
    check({tag, "_valid"}, 36'(board_valid), 36'd0);
    check({tag, "_start"}, 36'(start), 36'd0);
    check({tag, "_err"}, 36'(err_code), 36'd0);
  endtask

  initial begin
    int starts;
    reset_model();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Goal board submits cleanly; DONE holds until back.
    goto_pos(8);
    submit();
    repeat (20) @(negedge clk);
    check("valid_held", 36'(board_valid), 36'd1);
    press(3'b001);
    check("done_ignores_inc", board, pack_m());
    check("done_valid_after_inc", 36'(board_valid), 36'd1);
    leave(3'b100);

    // Short glitch on inc produces no press.
    btn_inc = 1'b1;
    repeat (3) @(negedge clk);
    btn_inc = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_ignored", 36'(cur_val), 36'(cells_m[0]));
    // Clean press, then wrap back round to 1.
    do_inc();
    repeat (8) do_inc();
    check("wrapped_cell0", 36'(cur_val), 36'd1);

    // Duplicate tile at index 1.
    goto_pos(1);
    repeat (8) do_inc();
    goto_pos(8);
    submit();
    leave(3'b010);
    check("cell1_kept", 36'(board[7:4]), 36'd1);
    goto_pos(1);
    do_inc();

    // Tiles 7 and 8 swapped: odd parity.
    goto_pos(6);
    do_inc();
    goto_pos(7);
    repeat (8) do_inc();
    goto_pos(8);
    submit();
    leave(3'b100);

    // Board 1,2,3,4,5,6,0,7,8: even parity.
    goto_pos(6);
    do_inc();
    goto_pos(8);
    repeat (8) do_inc();
    submit();
    leave(3'b100);
    press(3'b101);
    check("simul_cur_pos", 36'(cur_pos), 36'd0);
    check("simul_board", board, pack_m());

    // Reset mid CHECK_PAR.
    goto_pos(8);
    btn_next = 1'b1;
    for (int c = 1; c <= PRESS_AT + 20; c++) begin
      @(negedge clk);
      if (c == 6) btn_next = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("midcheck_reset");
    rst_n = 1'b1;
    reset_model();
    starts = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (start) starts++;
    end
    check("no_start_after_reset", 36'(starts), 36'd0);
    do_back();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
